watchtotx: RTL and testbench

Stopwatch-to-UART reporter: on request it snapshots the current stopwatch time and streams it as an ASCII frame, byte by byte, to the UART transmitter. It sits between the stopwatch counter and the TX datapath. It is the return path for the received-command decoder, which turns incoming ASCII bytes into go/pause/clear/up/receive controls. A "receive" command from the decoder is the normal source of `req`.

---
 rtl/uart_watch_pkg.sv | 63 ++++++
 rtl/bcd_to_ascii.sv | 16 +
 rtl/watchtotx.sv | 168 ++++++++++++++++
 tb/tb_watchtotx.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/uart_watch_pkg.sv
// Shared constants, FSM state and frame-slot types for the stopwatch-to-UART reporter (watchtotx).
// The optional status prefix is controlled by the WATCHTOTX_STATUS_EN macro in watchtotx.sv.
package uart_watch_pkg;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_DOT   = 8'h2E;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_G     = 8'h47;
  localparam logic [7:0] ASCII_P     = 8'h50;
  localparam logic [7:0] ASCII_U     = 8'h55;
  localparam logic [7:0] ASCII_D     = 8'h44;

  localparam int STATUS_LEN           = 2;
  localparam int FRAME_LEN_BASE       = 8;
  localparam int FRAME_LEN_EOL        = 10;
  localparam int FRAME_LEN_STATUS     = 10;
  localparam int FRAME_LEN_STATUS_EOL = 12;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_DONE
  } state_e;

  // Slot numbering follows the body byte order so an unprefixed index maps straight onto it.
  typedef enum logic [3:0] {
    SLOT_MIN_T = 4'd0,
    SLOT_MIN_U = 4'd1,
    SLOT_COLON = 4'd2,
    SLOT_SEC_T = 4'd3,
    SLOT_SEC_U = 4'd4,
    SLOT_DOT   = 4'd5,
    SLOT_CS_T  = 4'd6,
    SLOT_CS_U  = 4'd7,
    SLOT_CR    = 4'd8,
    SLOT_LF    = 4'd9,
    SLOT_RUN   = 4'd10,
    SLOT_DIR   = 4'd11
  } slot_e;

  typedef struct packed {
    logic [3:0] min_t;
    logic [3:0] min_u;
    logic [3:0] sec_t;
    logic [3:0] sec_u;
    logic [3:0] cs_t;
    logic [3:0] cs_u;
  } watch_time_t;

  function automatic int frame_len(input bit status_en, input bit eol_en);
    if (status_en) return eol_en ? FRAME_LEN_STATUS_EOL : FRAME_LEN_STATUS;
    return eol_en ? FRAME_LEN_EOL : FRAME_LEN_BASE;
  endfunction

  function automatic logic [7:0] status_char(input logic dir_byte, input logic flag);
    if (dir_byte) return flag ? ASCII_U : ASCII_D;
    return flag ? ASCII_G : ASCII_P;
  endfunction

endpackage

// File: rtl/bcd_to_ascii.sv
// Combinational BCD digit to ASCII character; non-decimal codes become '?'.
module bcd_to_ascii
  import uart_watch_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [7:0] ascii_o
);

  always_comb begin
    ascii_o = ASCII_QMARK;
    if (bcd_i <= 4'd9) begin
      ascii_o = ASCII_ZERO + {4'h0, bcd_i};
    end
  end

endmodule

// File: rtl/watchtotx.sv
// Stopwatch-to-UART reporter: snapshots the time on req and streams "MM:SS.CC[CR LF]" byte by byte.
// Define WATCHTOTX_STATUS_EN to prepend a run/pause and up/down status prefix to every frame.
module watchtotx
  import uart_watch_pkg::*;
#(
  parameter int FRAME_EOL = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic [3:0] min_t,
  input  logic [3:0] min_u,
  input  logic [3:0] sec_t,
  input  logic [3:0] sec_u,
  input  logic [3:0] cs_t,
  input  logic [3:0] cs_u,
  input  logic       running,
  input  logic       up,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       done
);

`ifdef WATCHTOTX_STATUS_EN
  localparam bit STATUS_EN = 1'b1;
`else
  localparam bit STATUS_EN = 1'b0;
`endif
  localparam int         FRAME_LEN = frame_len(STATUS_EN, FRAME_EOL != 0);
  localparam logic [3:0] LAST_IDX  = 4'(FRAME_LEN - 1);

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  watch_time_t snap_q, snap_d;
  logic        load;

  slot_e       slot;
  logic [3:0]  digit_sel;
  logic        use_digit;
  logic [7:0]  lit_byte;
  logic [7:0]  digit_ascii;
  logic [7:0]  frame_byte;

  always_comb begin
    snap_d = snap_q;
    if (load) begin
      snap_d = '{min_t: min_t, min_u: min_u, sec_t: sec_t,
                 sec_u: sec_u, cs_t: cs_t, cs_u: cs_u};
    end
  end

`ifdef WATCHTOTX_STATUS_EN
  logic running_q, up_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running_q <= 1'b0;
      up_q      <= 1'b0;
    end else if (load) begin
      running_q <= running;
      up_q      <= up;
    end
  end

  always_comb begin
    if (idx_q == 4'd0) begin
      slot = SLOT_RUN;
    end else if (idx_q == 4'd1) begin
      slot = SLOT_DIR;
    end else begin
      slot = slot_e'(idx_q - 4'(STATUS_LEN));
    end
  end
`else
  logic unused_status;
  assign unused_status = running ^ up;

  always_comb begin
    slot = slot_e'(idx_q);
  end
`endif

  // Only one digit is on the wire at a time, so a single converter sits behind the digit mux.
  always_comb begin
    digit_sel = 4'h0;
    use_digit = 1'b0;
    lit_byte  = 8'h00;
    case (slot)
      SLOT_MIN_T: begin digit_sel = snap_q.min_t; use_digit = 1'b1; end
      SLOT_MIN_U: begin digit_sel = snap_q.min_u; use_digit = 1'b1; end
      SLOT_SEC_T: begin digit_sel = snap_q.sec_t; use_digit = 1'b1; end
      SLOT_SEC_U: begin digit_sel = snap_q.sec_u; use_digit = 1'b1; end
      SLOT_CS_T:  begin digit_sel = snap_q.cs_t;  use_digit = 1'b1; end
      SLOT_CS_U:  begin digit_sel = snap_q.cs_u;  use_digit = 1'b1; end
      SLOT_COLON: lit_byte = ASCII_COLON;
      SLOT_DOT:   lit_byte = ASCII_DOT;
      SLOT_CR:    lit_byte = ASCII_CR;
      SLOT_LF:    lit_byte = ASCII_LF;
`ifdef WATCHTOTX_STATUS_EN
      SLOT_RUN:   lit_byte = status_char(1'b0, running_q);
      SLOT_DIR:   lit_byte = status_char(1'b1, up_q);
`endif
      default:    lit_byte = 8'h00;
    endcase
  end

  bcd_to_ascii u_bcd_to_ascii (
    .bcd_i   (digit_sel),
    .ascii_o (digit_ascii)
  );

  assign frame_byte = use_digit ? digit_ascii : lit_byte;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    load     = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d = ST_SEND;
          idx_d   = 4'd0;
          load    = 1'b1;
        end
      end
      ST_SEND: begin
        tx_valid = 1'b1;
        tx_data  = frame_byte;
        busy     = 1'b1;
        if (tx_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
            idx_d   = 4'd0;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= 4'd0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
    end
  end

endmodule

// File: tb/tb_watchtotx.sv
// Directed bench for watchtotx: frame contents, back-pressure, snapshot, req handling, '?' and reset.
module tb_watchtotx;

`ifdef WATCHTOTX_STATUS_EN
  localparam int PRE = 2;
`else
  localparam int PRE = 0;
`endif
  localparam int LEN = 10 + PRE;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req = 1'b0;
  logic [3:0] minT = 4'd0, minU = 4'd0, secT = 4'd0, secU = 4'd0, csT = 4'd0, csU = 4'd0;
  logic       running = 1'b1;
  logic       up = 1'b0;
  logic       txReady = 1'b1;
  logic [7:0] txData;
  logic       txValid;
  logic       busy;
  logic       done;

  int checks = 0;
  int failures = 0;
  logic [7:0] curBody [10];

  watchtotx #(.FRAME_EOL(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .min_t    (minT),
    .min_u    (minU),
    .sec_t    (secT),
    .sec_u    (secU),
    .cs_t     (csT),
    .cs_u     (csU),
    .running  (running),
    .up       (up),
    .tx_data  (txData),
    .tx_valid (txValid),
    .tx_ready (txReady),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] a, b, c, d, e, f);
    minT = a; minU = b; secT = c; secU = d; csT = e; csU = f;
  endtask

  // Expected status prefix with running=1, up=0 is 'G' 'D'.
  function automatic logic [7:0] expByte(input int k);
    if (k < PRE) return (k == 0) ? 8'h47 : 8'h44;
    return curBody[k - PRE];
  endfunction

  task automatic startFrame();
    req = 1'b1;
    tick();
    req = 1'b0;
  endtask

  task automatic receiveFrame(input string name, input int stallAt, input int changeAt,
                              input int reqAt, input bit holdReq);
    for (int k = 0; k < LEN; k++) begin
      if (k == changeAt) applyStimulus(4'd9, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9);
      req = holdReq | (k == reqAt);
      if (k == stallAt) begin
        txReady = 1'b0;
        for (int s = 0; s < 3; s++) begin
          checkOutput($sformatf("%s stall%0d data", name, s), txData, expByte(k));
          checkOutput($sformatf("%s stall%0d valid", name, s), txValid, 1);
          tick();
        end
        txReady = 1'b1;
      end
      checkOutput($sformatf("%s byte%0d data", name, k), txData, expByte(k));
      checkOutput($sformatf("%s byte%0d valid", name, k), txValid, 1);
      checkOutput($sformatf("%s byte%0d busy", name, k), busy, 1);
      tick();
    end
    req = holdReq;
    checkOutput($sformatf("%s done pulse", name), done, 1);
    checkOutput($sformatf("%s done busy", name), busy, 0);
    checkOutput($sformatf("%s done valid", name), txValid, 0);
    checkOutput($sformatf("%s done data", name), txData, 8'h00);
    tick();
    checkOutput($sformatf("%s done cleared", name), done, 0);
    checkOutput($sformatf("%s idle valid", name), txValid, 0);
  endtask

  initial begin
    tick();
    tick();
    checkOutput("reset data", txData, 8'h00);
    checkOutput("reset valid", txValid, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    rst_n = 1'b1;
    tick();
    checkOutput("idle no req", txValid, 0);

    applyStimulus(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    curBody = '{8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h2E, 8'h35, 8'h36, 8'h0D, 8'h0A};
    startFrame();
    receiveFrame("basic", -1, -1, -1, 1'b0);

    startFrame();
    receiveFrame("stall", 4 + PRE, -1, -1, 1'b0);

    startFrame();
    receiveFrame("snapshot", -1, 3, -1, 1'b0);
    applyStimulus(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);

    startFrame();
    receiveFrame("midreq", -1, -1, 5, 1'b0);
    tick();
    checkOutput("midreq no second frame", txValid, 0);
    checkOutput("midreq not busy", busy, 0);

    req = 1'b1;
    tick();
    receiveFrame("held1", -1, -1, -1, 1'b1);
    tick();
    receiveFrame("held2", -1, -1, -1, 1'b0);

    applyStimulus(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'hB);
    curBody = '{8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h2E, 8'h35, 8'h3F, 8'h0D, 8'h0A};
    startFrame();
    receiveFrame("qmark", -1, -1, -1, 1'b0);

    applyStimulus(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    curBody = '{8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h2E, 8'h35, 8'h36, 8'h0D, 8'h0A};
    startFrame();
    for (int k = 0; k < 5 + PRE; k++) begin
      checkOutput($sformatf("abort byte%0d data", k), txData, expByte(k));
      tick();
    end
    rst_n = 1'b0;
    #1;
    checkOutput("abort valid", txValid, 0);
    checkOutput("abort busy", busy, 0);
    checkOutput("abort data", txData, 8'h00);
    checkOutput("abort done", done, 0);
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("abort idle", txValid, 0);
    startFrame();
    receiveFrame("after reset", -1, -1, -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
